// File: rtl/pe_opsum_drain.sv
// Drains packed 4-lane opsum words from the PE FIFO onto a 16-bit valid/ready stream and counts p*n*F psums.
// Optional build macro PSUM_RELU_EN clamps negative lanes to zero on the way out.
module pe_opsum_drain #(
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_WIDTH_PSUM = 64,
  parameter int F_WIDTH         = 6,
  parameter int n_WIDTH         = 3,
  parameter int p_WIDTH         = 5,
  parameter int CNT_WIDTH       = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       configure,
  input  logic [F_WIDTH-1:0]         F,
  input  logic [n_WIDTH-1:0]         n,
  input  logic [p_WIDTH-1:0]         p,
  output logic                       busy,
  output logic                       done,
  input  logic [DATA_WIDTH_PSUM-1:0] opsum,
  input  logic                       opsum_fifo_empty,
  output logic                       pop_opsum,
  output logic [DATA_WIDTH-1:0]      psum_out,
  output logic                       psum_valid,
  input  logic                       psum_ready,
  output logic                       psum_last
);

  localparam int LANES  = DATA_WIDTH_PSUM / DATA_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PROD_W = F_WIDTH + n_WIDTH + p_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  state_t                             state, state_next;
  logic [LANES-1:0][DATA_WIDTH-1:0]   hold;
  logic [LANE_W-1:0]                  lane;
  logic [CNT_WIDTH-1:0]               emitted, total, total_cfg;
  logic                               cfg_ok, fetch, handshake;
  logic [DATA_WIDTH-1:0]              lane_data;

  // Product formed at full width, then truncated into the counter width
  assign total_cfg = CNT_WIDTH'(PROD_W'(p) * PROD_W'(n) * PROD_W'(F));
  assign cfg_ok    = configure && (state == IDLE || state == DONE);
  assign fetch     = (state == FETCH) && enable && !opsum_fifo_empty;
  assign handshake = psum_valid && psum_ready && enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      hold    <= '0;
      lane    <= '0;
      emitted <= '0;
      total   <= '0;
    end else begin
      state <= state_next;
      if (cfg_ok) begin
        total   <= total_cfg;
        emitted <= '0;
        lane    <= '0;
      end
      if (fetch) begin
        hold <= opsum;
        lane <= '0;
      end
      if (handshake) begin
        emitted <= emitted + CNT_WIDTH'(1);
        lane    <= lane + LANE_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    pop_opsum  = 1'b0;
    psum_valid = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (configure)
          state_next = (total_cfg == '0) ? DONE : FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        pop_opsum = fetch;
        if (fetch)
          state_next = EMIT;
      end
      EMIT: begin
        busy       = 1'b1;
        psum_valid = 1'b1;
        // Reaching the total wins over the word boundary; leftover lanes are dropped
        if (handshake) begin
          if (emitted + CNT_WIDTH'(1) == total)
            state_next = DONE;
          else if (lane == LANE_W'(LANES - 1))
            state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign lane_data = hold[lane];
  assign psum_last = psum_valid && (emitted == total - CNT_WIDTH'(1));

`ifdef PSUM_RELU_EN
  assign psum_out = lane_data[DATA_WIDTH-1] ? '0 : lane_data;
`else
  assign psum_out = lane_data;
`endif

endmodule
